nes_ctrl_port: RTL and testbench



---
 rtl/nes_ctrl_port.sv | 89 ++++++++
 tb/tb_nes_ctrl_port.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_ctrl_port.sv
// NES controller port ($4016/$4017): strobe latch, per-port serial shift registers, Zapper merge on port 2.
// Latency: dout is registered on the rd_en edge and is valid the following cycle; it holds until the next read.
// Backpressure: none; the CPU interface is a pulse interface and every read/write is accepted.
// Optional: define NES_CTRL_PORT_FOUR_SCORE_EN for the 4-player adapter (joy3/joy4, 24-bit registers).
module nes_ctrl_port #(
  parameter logic SHIFT_FILL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_strobe,
  input  logic       wr_data,
  input  logic       rd_en,
  input  logic       rd_port,
  input  logic [7:0] joy1,
  input  logic [7:0] joy2,
`ifdef NES_CTRL_PORT_FOUR_SCORE_EN
  input  logic [7:0] joy3,
  input  logic [7:0] joy4,
`endif
  input  logic       zapper_en,
  input  logic       light,
  input  logic       trigger,
  output logic [4:0] dout,
  output logic       strobe
);

`ifdef NES_CTRL_PORT_FOUR_SCORE_EN
  // Adapter signature bytes follow the second pad; port 1 reports on read 20, port 2 on read 19.
  localparam int W = 24;
`else
  localparam int W = 8;
`endif

  logic [W-1:0] sr1;
  logic [W-1:0] sr2;
  logic [W-1:0] load1;
  logic [W-1:0] load2;
  logic         reload;
  logic         shift1;
  logic         shift2;
  logic [4:0]   rd_val;

`ifdef NES_CTRL_PORT_FOUR_SCORE_EN
  assign load1 = {8'h08, joy3, joy1};
  assign load2 = {8'h04, joy4, joy2};
`else
  assign load1 = joy1;
  assign load2 = joy2;
`endif

  // Decide reload/shift and form the read word from the pre-write strobe value.
  always_comb begin
    rd_val = 5'b00000;
    // A 1-write in the same cycle as a read takes priority over that read's shift.
    reload = strobe | (wr_strobe & wr_data);
    shift1 = rd_en & ~strobe & ~rd_port;
    shift2 = rd_en & ~strobe & rd_port;
    if (!rd_port) begin
      rd_val[0] = strobe ? joy1[0] : sr1[0];
    end else if (zapper_en) begin
      rd_val[3] = light;
      rd_val[4] = trigger;
    end else begin
      rd_val[0] = strobe ? joy2[0] : sr2[0];
    end
  end

  // Strobe latch, registered read data and both shift registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      strobe <= 1'b0;
      dout   <= 5'b00000;
      sr1    <= {W{SHIFT_FILL}};
      sr2    <= {W{SHIFT_FILL}};
    end else begin
      if (wr_strobe) strobe <= wr_data;
      if (rd_en)     dout   <= rd_val;
      if (reload) begin
        sr1 <= load1;
        sr2 <= load2;
      end else begin
        // Port 2 shifts even when the Zapper owns the read data.
        if (shift1) sr1 <= {SHIFT_FILL, sr1[W-1:1]};
        if (shift2) sr2 <= {SHIFT_FILL, sr2[W-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_nes_ctrl_port.sv
// Bench for nes_ctrl_port: directed scenarios with fixed expectations plus a randomized run
// checked against a reference model that tracks a captured snapshot and a read position per port.
module tb_nes_ctrl_port;

`ifdef NES_CTRL_PORT_FOUR_SCORE_EN
  localparam int W = 24;
`else
  localparam int W = 8;
`endif
  localparam logic FILL = 1'b1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_strobe = 1'b0, wr_data = 1'b0, rd_en = 1'b0, rd_port = 1'b0;
  logic [7:0] joy1 = 8'h00, joy2 = 8'h00;
`ifdef NES_CTRL_PORT_FOUR_SCORE_EN
  logic [7:0] joy3 = 8'h00, joy4 = 8'h00;
`endif
  logic       zapper_en = 1'b0, light = 1'b1, trigger = 1'b0;
  logic [4:0] dout;
  logic       strobe;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nes_ctrl_port #(.SHIFT_FILL(FILL)) dut (
    .clk(clk), .reset(reset), .wr_strobe(wr_strobe), .wr_data(wr_data),
    .rd_en(rd_en), .rd_port(rd_port), .joy1(joy1), .joy2(joy2),
`ifdef NES_CTRL_PORT_FOUR_SCORE_EN
    .joy3(joy3), .joy4(joy4),
`endif
    .zapper_en(zapper_en), .light(light), .trigger(trigger),
    .dout(dout), .strobe(strobe)
  );

  // Reference model: snapshot of the pad word, and how many bits of it were already read.
  logic         m_strobe = 1'b0;
  logic [W-1:0] m_snap1 = '0, m_snap2 = '0;
  int           m_pos1 = W, m_pos2 = W;
  logic [4:0]   m_dout = 5'b0;

  function automatic logic [W-1:0] word1();
`ifdef NES_CTRL_PORT_FOUR_SCORE_EN
    return {8'h08, joy3, joy1};
`else
    return joy1;
`endif
  endfunction

  function automatic logic [W-1:0] word2();
`ifdef NES_CTRL_PORT_FOUR_SCORE_EN
    return {8'h04, joy4, joy2};
`else
    return joy2;
`endif
  endfunction

  function automatic logic mbit(input logic [W-1:0] s, input int p);
    return (p < W) ? s[p] : FILL;
  endfunction

  task automatic model_edge();
    logic old_s;
    old_s = m_strobe;
    if (reset) begin
      m_strobe = 1'b0;
      m_dout   = 5'b0;
      m_pos1   = W;
      m_pos2   = W;
      return;
    end
    if (rd_en) begin
      if (!rd_port)       m_dout = {4'b0, old_s ? joy1[0] : mbit(m_snap1, m_pos1)};
      else if (zapper_en) m_dout = {trigger, light, 3'b000};
      else                m_dout = {4'b0, old_s ? joy2[0] : mbit(m_snap2, m_pos2)};
      if (!old_s) begin
        if (!rd_port && m_pos1 < W) m_pos1++;
        if (rd_port && m_pos2 < W)  m_pos2++;
      end
    end
    if (old_s || (wr_strobe && wr_data)) begin
      m_snap1 = word1();
      m_snap2 = word2();
      m_pos1  = 0;
      m_pos2  = 0;
    end
    if (wr_strobe) m_strobe = wr_data;
  endtask

  // One bus cycle: drive on the falling edge, model at the rising edge, release pulses 1ns later.
  task automatic tick(input logic wr, input logic wd, input logic rd, input logic port);
    @(negedge clk);
    wr_strobe = wr;
    wr_data   = wd;
    rd_en     = rd;
    rd_port   = port;
    @(posedge clk);
    model_edge();
    #1;
    wr_strobe = 1'b0;
    rd_en     = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (dout !== 5'b00000) begin n_err++; $display("FAIL reset dout: got %b want 00000", dout); end
    n_cmp++;
    if (strobe !== 1'b0) begin n_err++; $display("FAIL reset strobe: got %b want 0", strobe); end
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 10; i++) begin
        tick(0, 0, 1, p[0]);
        n_cmp++;
        if (dout !== 5'b00001 || strobe !== 1'b0) begin
          n_err++;
          $display("FAIL reset_read port%0d #%0d: dout=%b strobe=%b want 00001/0", p + 1, i + 1, dout, strobe);
        end
      end
    end
  endtask

  task automatic test_serial();
    logic [8:0] seq;
    seq  = 9'b1_1000_0101;   // read i expects seq[i]; read 9 is fill
    joy1 = 8'b1000_0101;
    tick(1, 1, 0, 0);
    tick(1, 0, 0, 0);
    joy1 = 8'h00;
    for (int i = 0; i < 9; i++) begin
      tick(0, 0, 1, 0);
      n_cmp++;
      if (dout !== {4'b0, seq[i]}) begin
        n_err++;
        $display("FAIL serial read %0d: got %b want %b", i + 1, dout, {4'b0, seq[i]});
      end
    end
  endtask

  task automatic test_strobe_held();
    tick(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      joy1 = {7'b0101010, ~joy1[0]};
      tick(0, 0, 1, 0);
      n_cmp++;
      if (dout !== {4'b0, joy1[0]}) begin
        n_err++;
        $display("FAIL strobe_held read %0d: got %b want %b", i + 1, dout, {4'b0, joy1[0]});
      end
    end
    tick(1, 0, 0, 0);
    n_cmp++;
    if (strobe !== 1'b0) begin n_err++; $display("FAIL strobe_drop: strobe=%b want 0", strobe); end
    tick(0, 0, 1, 0);
    n_cmp++;
    if (dout !== {4'b0, joy1[0]}) begin
      n_err++;
      $display("FAIL strobe_drop first read: got %b want %b", dout, {4'b0, joy1[0]});
    end
    tick(0, 0, 1, 0);
    n_cmp++;
    if (dout !== {4'b0, joy1[1]}) begin
      n_err++;
      $display("FAIL strobe_drop second read: got %b want %b", dout, {4'b0, joy1[1]});
    end
  endtask

  task automatic test_zapper();
    zapper_en = 1'b1;
    light = 1'b0;
    trigger = 1'b1;
    tick(0, 0, 1, 1);
    n_cmp++;
    if (dout !== 5'b10000) begin n_err++; $display("FAIL zapper trig: got %b want 10000", dout); end
    light = 1'b1;
    trigger = 1'b0;
    tick(0, 0, 1, 1);
    n_cmp++;
    if (dout !== 5'b01000) begin n_err++; $display("FAIL zapper light: got %b want 01000", dout); end
    zapper_en = 1'b0;
  endtask

  task automatic test_simultaneous();
    joy1 = 8'b0000_0100;
    tick(1, 1, 0, 0);
    tick(1, 0, 0, 0);
    joy1 = 8'b1111_1010;
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 0);
    n_cmp++;
    if (dout !== 5'b00000) begin n_err++; $display("FAIL simul pre read: got %b want 00000", dout); end
    tick(1, 1, 1, 0);      // third read collides with a 1-write
    n_cmp++;
    if (dout !== 5'b00001) begin n_err++; $display("FAIL simul old bit: got %b want 00001", dout); end
    tick(1, 0, 0, 0);
    tick(0, 0, 1, 0);
    n_cmp++;
    if (dout !== 5'b00000) begin n_err++; $display("FAIL simul reload bit0: got %b want 00000", dout); end
    tick(0, 0, 1, 0);
    n_cmp++;
    if (dout !== 5'b00001) begin n_err++; $display("FAIL simul reload bit1: got %b want 00001", dout); end
  endtask

  task automatic test_reset_mid();
    joy1 = 8'h00;
    tick(1, 1, 0, 0);
    tick(1, 0, 0, 0);
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 0);
    do_reset();
    n_cmp++;
    if (dout !== 5'b00000 || strobe !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid state: dout=%b strobe=%b want 00000/0", dout, strobe);
    end
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1, 0);
      n_cmp++;
      if (dout !== 5'b00001) begin n_err++; $display("FAIL reset_mid read %0d: got %b want 00001", i + 1, dout); end
    end
  endtask

`ifdef NES_CTRL_PORT_FOUR_SCORE_EN
  task automatic test_four_score();
    logic exp;
    joy1 = 8'h00; joy2 = 8'h00; joy3 = 8'h01; joy4 = 8'h00;
    tick(1, 1, 0, 0);
    tick(1, 0, 0, 0);
    for (int p = 0; p < 2; p++) begin
      for (int i = 1; i <= 25; i++) begin
        tick(0, 0, 1, p[0]);
        if (p == 0) exp = (i == 9 || i == 20 || i == 25);
        else        exp = (i == 19 || i == 25);
        n_cmp++;
        if (dout !== {4'b0, exp}) begin
          n_err++;
          $display("FAIL four_score port%0d read %0d: got %b want %b", p + 1, i, dout, {4'b0, exp});
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      joy1 = 8'($urandom);
      joy2 = 8'($urandom);
`ifdef NES_CTRL_PORT_FOUR_SCORE_EN
      joy3 = 8'($urandom);
      joy4 = 8'($urandom);
`endif
      zapper_en = ($urandom_range(0, 3) == 0);
      light     = 1'($urandom);
      trigger   = 1'($urandom);
      tick(($urandom_range(0, 11) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
      n_cmp++;
      if (dout !== m_dout || strobe !== m_strobe) begin
        n_err++;
        $display("FAIL random cycle %0d: dout=%b strobe=%b want %b/%b", i, dout, strobe, m_dout, m_strobe);
      end
    end
    zapper_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_serial();
    test_strobe_held();
    test_zapper();
    test_simultaneous();
    test_reset_mid();
`ifdef NES_CTRL_PORT_FOUR_SCORE_EN
    test_four_score();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
